// File: rtl/ram_block_mover.sv
// Copy/fill engine driving port B of the block RAM: one command at a time,
// byte-serial reads and writes, with abort and a done/aborted handshake.
module ram_block_mover #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_fill,
    input  logic [ADDR_WIDTH-1:0] cmd_src,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_value,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH-1:0] remaining,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        FILL,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   src_addr;
    logic [ADDR_WIDTH-1:0]   dst_addr;
    logic [DATA_WIDTH-1:0]   fill_value;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Abort wins over the pending write: no counter moves, remaining keeps
    // the count of bytes that never reached the RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            src_addr   <= '0;
            dst_addr   <= '0;
            fill_value <= '0;
            remaining  <= '0;
            aborted    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        src_addr   <= cmd_src;
                        dst_addr   <= cmd_dst;
                        fill_value <= cmd_value;
                        remaining  <= cmd_len;
                        aborted    <= 1'b0;
                        if (cmd_len == '0) begin
                            state <= DONE;
                        end else if (cmd_fill) begin
                            state <= FILL;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= WR;
                    end
                end
                WR: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= DONE;
                    end else begin
                        src_addr  <= src_addr + ONE;
                        dst_addr  <= dst_addr + ONE;
                        remaining <= remaining - ONE;
                        state     <= (remaining == ONE) ? DONE : RD;
                    end
                end
                FILL: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= DONE;
                    end else begin
                        dst_addr  <= dst_addr + ONE;
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Port B decode; the copy data comes straight from dob read in RD.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state)
            RD: begin
                ram_addr = src_addr;
            end
            WR: begin
                ram_we   = ~abort & ~reset;
                ram_addr = dst_addr;
                ram_din  = ram_dout;
            end
            FILL: begin
                ram_we   = ~abort & ~reset;
                ram_addr = dst_addr;
                ram_din  = fill_value;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ram_block_mover.sv
// Directed bench for ram_block_mover: behavioural RAM on port B, a reference
// memory that predicts each write into a scoreboard queue, and end-state checks.
module tb_ram_block_mover;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_fill;
    logic [15:0] cmd_src;
    logic [15:0] cmd_dst;
    logic [15:0] cmd_len;
    logic [7:0]  cmd_value;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] remaining;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    logic [7:0]  mem    [0:65535];
    logic [7:0]  refMem [0:65535];
    wr_t         expQ[$];

    int errors = 0;
    int checks = 0;
    int doneCount = 0;
    int expDone = 0;

    ram_block_mover #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_fill  (cmd_fill),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .cmd_value (cmd_value),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .remaining (remaining),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port B of the block RAM: 1-cycle read latency, dob held during writes.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] = ram_din;
        end else begin
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (done) doneCount++;
        if (ram_we === 1'b1) begin
            checkOutput("unexpected_write", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
                wr_t w;
                w = expQ.pop_front();
                checkOutput("write_addr", ram_addr, w.addr);
                checkOutput("write_data", ram_din, w.data);
            end
        end
    end

    task automatic preload(input logic [15:0] addr, input logic [7:0] data);
        mem[addr]    = data;
        refMem[addr] = data;
    endtask

    // Predicts up to maxWrites writes, then presents the command for one cycle.
    task automatic applyStimulus(input logic fill, input logic [15:0] src,
                                 input logic [15:0] dst, input logic [15:0] len,
                                 input logic [7:0] value, input int maxWrites);
        for (int i = 0; i < int'(len) && i < maxWrites; i++) begin
            wr_t w;
            w.addr = dst + 16'(i);
            w.data = fill ? value : refMem[src + 16'(i)];
            refMem[w.addr] = w.data;
            expQ.push_back(w);
        end
        cmd_fill  = fill;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        cmd_value = value;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output logic [31:0] weBits,
                            output logic doneAborted, output logic [15:0] doneRemaining);
        logic seen;
        seen = 1'b0;
        cycles = 0;
        weBits = '0;
        doneAborted = 1'b0;
        doneRemaining = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                doneAborted = aborted;
                doneRemaining = remaining;
                break;
            end
            weBits = {weBits[30:0], ram_we};
            cycles++;
        end
        if (!seen) checkOutput("done_timeout", 0, 1);
        @(posedge clk);
        #1;
        checkOutput("writes_pending", expQ.size(), 0);
    endtask

    initial begin
        int          cycles;
        logic [31:0] weBits;
        logic        ab;
        logic [15:0] rem;

        for (int a = 0; a < 65536; a++) begin
            mem[a]    = 8'h00;
            refMem[a] = 8'h00;
        end
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_fill = 1'b0;
        cmd_src = '0;
        cmd_dst = '0;
        cmd_len = '0;
        cmd_value = '0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_aborted", aborted, 0);
        checkOutput("rst_remaining", remaining, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_ram_din", ram_din, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Fill 4 bytes: one write per cycle, neighbour untouched
        preload(16'h1004, 8'hEE);
        applyStimulus(1'b1, 16'h0000, 16'h1000, 16'd4, 8'hAA, 1000);
        expDone++;
        checkOutput("fill_busy", busy, 1);
        waitDone(cycles, weBits, ab, rem);
        checkOutput("fill_cycles", cycles, 4);
        checkOutput("fill_we", weBits[3:0], 4'b1111);
        checkOutput("fill_aborted", ab, 0);
        for (int i = 0; i < 4; i++) checkOutput("fill_mem", mem[16'h1000 + 16'(i)], 8'hAA);
        checkOutput("fill_untouched", mem[16'h1004], 8'hEE);

        // Copy 3 bytes at two cycles per byte
        preload(16'h0200, 8'h11);
        preload(16'h0201, 8'h22);
        preload(16'h0202, 8'h33);
        applyStimulus(1'b0, 16'h0200, 16'h0300, 16'd3, 8'h00, 1000);
        expDone++;
        waitDone(cycles, weBits, ab, rem);
        checkOutput("copy_cycles", cycles, 6);
        checkOutput("copy_we", weBits[5:0], 6'b010101);
        checkOutput("copy_mem0", mem[16'h0300], 8'h11);
        checkOutput("copy_mem1", mem[16'h0301], 8'h22);
        checkOutput("copy_mem2", mem[16'h0302], 8'h33);

        // Fill across the top of the address space
        applyStimulus(1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'h55, 1000);
        expDone++;
        waitDone(cycles, weBits, ab, rem);
        checkOutput("wrap_mem_ffff", mem[16'hFFFF], 8'h55);
        checkOutput("wrap_mem_0001", mem[16'h0001], 8'h55);

        // Abort on the 4th fill cycle
        preload(16'h2003, 8'hC3);
        applyStimulus(1'b1, 16'h0000, 16'h2000, 16'd10, 8'h3C, 3);
        expDone++;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort_we", ram_we, 0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_cmd_ready", cmd_ready, 0);
        waitDone(cycles, weBits, ab, rem);
        checkOutput("abort_done_latency", cycles, 0);
        checkOutput("abort_flag", ab, 1);
        checkOutput("abort_remaining", rem, 7);
        checkOutput("abort_untouched", mem[16'h2003], 8'hC3);

        // Next command is accepted and clears aborted
        applyStimulus(1'b1, 16'h0000, 16'h2100, 16'd2, 8'h66, 1000);
        expDone++;
        waitDone(cycles, weBits, ab, rem);
        checkOutput("post_abort_flag", ab, 0);
        checkOutput("post_abort_cycles", cycles, 2);

        // Zero-length command
        applyStimulus(1'b0, 16'h0000, 16'h3000, 16'd0, 8'h00, 1000);
        expDone++;
        waitDone(cycles, weBits, ab, rem);
        checkOutput("len0_cycles", cycles, 0);
        checkOutput("len0_aborted", ab, 0);

        // Reset in the RD cycle after the 2nd write of an 8-byte copy
        for (int i = 0; i < 8; i++) preload(16'h0400 + 16'(i), 8'h80 + 8'(i));
        preload(16'h0502, 8'h5A);
        applyStimulus(1'b0, 16'h0400, 16'h0500, 16'd8, 8'h00, 2);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midrst_cmd_ready", cmd_ready, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_remaining", remaining, 0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("midrst_pending", expQ.size(), 0);
        checkOutput("midrst_untouched", mem[16'h0502], 8'h5A);
        checkOutput("midrst_mem1", mem[16'h0501], 8'h81);

        // Overlapping ascending copy replicates the first byte
        preload(16'h0010, 8'h07);
        preload(16'h0011, 8'h99);
        preload(16'h0012, 8'h98);
        preload(16'h0013, 8'h97);
        applyStimulus(1'b0, 16'h0010, 16'h0011, 16'd3, 8'h00, 1000);
        expDone++;
        waitDone(cycles, weBits, ab, rem);
        for (int i = 1; i <= 3; i++) checkOutput("overlap_mem", mem[16'h0010 + 16'(i)], 8'h07);

        @(posedge clk);
        #1;
        checkOutput("done_count", doneCount, expDone);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
